// File: rtl/dcache_req_adapter.sv
// dcache_req_adapter
//
// Turns a simple valid/ready load/store request into the split handshake
// used by the data cache. The index and write fields go out first,
// together with data_req_o. Once the cache grants, the tag is sent one
// cycle later with tag_valid_o. A read then waits for data_rvalid_i and
// returns the data to the requester for a single cycle. Only one request
// can be outstanding at a time.
//
// kill_i can abort the outstanding request at any point:
//   - before the grant, the request is dropped with no cache activity;
//   - at or after the grant, kill_req_o is raised in the tag cycle;
//   - after the tag, any read data still in flight is drained silently.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid_i/req_ready_o   upstream request handshake
//   req_addr_i                byte address: [INDEX_W-1:0] index, rest is the tag
//   req_we_i/be_i/wdata_i     write enable, byte enables, write data
//   kill_i                    abort the outstanding request
//   resp_valid_o/rdata_o      one-cycle read response
//   address_index_o/tag_o     cache index (request phase) and tag (tag phase)
//   data_wdata_o/we_o/be_o    write fields presented with the request
//   data_req_o/data_gnt_i     cache request handshake
//   tag_valid_o/kill_req_o    tag strobe and abort indication to the cache
//   data_rvalid_i/rdata_i     cache read return
module dcache_req_adapter #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [INDEX_W+TAG_W-1:0] req_addr_i,
    input  logic                     req_we_i,
    input  logic [7:0]               req_be_i,
    input  logic [63:0]              req_wdata_i,
    input  logic                     kill_i,
    output logic                     resp_valid_o,
    output logic [63:0]              resp_rdata_o,
    output logic [INDEX_W-1:0]       address_index_o,
    output logic [TAG_W-1:0]         address_tag_o,
    output logic [63:0]              data_wdata_o,
    output logic                     data_we_o,
    output logic [7:0]               data_be_o,
    output logic                     data_req_o,
    input  logic                     data_gnt_i,
    output logic                     kill_req_o,
    output logic                     tag_valid_o,
    input  logic                     data_rvalid_i,
    input  logic [63:0]              data_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        TAG,
        WAIT_R,
        DRAIN
    } state_t;

    state_t             r_state;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_tag;
    logic               r_we;
    logic [7:0]         r_be;
    logic [63:0]        r_wdata;
    logic [63:0]        r_rdata;
    logic               r_resp_valid;
    logic               r_kill_pend;

    logic               w_accept;
    logic               w_tag_killed;

    // Ready is gated by rst so that nothing is offered while reset is held,
    // even in the first reset cycle before the state has been forced.
    assign req_ready_o  = (r_state == IDLE) & ~kill_i & ~rst;
    assign w_accept     = req_valid_i & req_ready_o;

    // A kill seen together with the grant is remembered in r_kill_pend
    // and reported in the tag cycle alongside any fresh kill_i.
    assign w_tag_killed = kill_i | r_kill_pend;

    assign data_req_o   = (r_state == REQ);
    assign tag_valid_o  = (r_state == TAG);
    assign kill_req_o   = (r_state == TAG) & w_tag_killed;

    // Address and data fields always show the registered values so they
    // stay stable across grant stalls and hold after the transaction ends.
    assign address_index_o = r_index;
    assign address_tag_o   = r_tag;
    assign data_wdata_o    = r_wdata;
    assign data_we_o       = r_we;
    assign data_be_o       = r_be;
    assign resp_valid_o    = r_resp_valid;
    assign resp_rdata_o    = r_rdata;

    // Request sequencing. The read response is a registered one-cycle
    // pulse raised on the same edge that returns the FSM to IDLE, so a
    // new request can already be taken while the response is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_tag        <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_kill_pend  <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill_pend <= 1'b0;
                    if (w_accept) begin
                        r_index <= req_addr_i[INDEX_W-1:0];
                        r_tag   <= req_addr_i[INDEX_W+TAG_W-1:INDEX_W];
                        r_we    <= req_we_i;
                        r_be    <= req_be_i;
                        r_wdata <= req_wdata_i;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        r_kill_pend <= kill_i;
                        r_state     <= TAG;
                    end else if (kill_i) begin
                        r_state <= IDLE;
                    end
                end
                TAG: begin
                    // r_kill_pend only matters in this cycle, and every
                    // path out of here either reaches IDLE or no longer
                    // needs it.
                    r_kill_pend <= 1'b0;
                    if (w_tag_killed || r_we) begin
                        r_state <= IDLE;
                    end else if (data_rvalid_i) begin
                        r_rdata      <= data_rdata_i;
                        r_resp_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_state <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (data_rvalid_i) begin
                        if (!kill_i) begin
                            r_rdata      <= data_rdata_i;
                            r_resp_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (kill_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (data_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_adapter.sv
// tb_dcache_req_adapter
//
// Bench for dcache_req_adapter. Each request is described at the
// transaction level by the following parameters:
//   - grant delay;
//   - read latency counted from the tag cycle;
//   - where, if anywhere, a kill lands.
// The expected cycle-by-cycle trace is derived from those latency and
// kill rules. It is used both for directed cases and for a run of
// $urandom-generated requests.
module tb_dcache_req_adapter;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [55:0] req_addr_i;
    logic        req_we_i;
    logic [7:0]  req_be_i;
    logic [63:0] req_wdata_i;
    logic        kill_i;
    logic        resp_valid_o;
    logic [63:0] resp_rdata_o;
    logic [11:0] address_index_o;
    logic [43:0] address_tag_o;
    logic [63:0] data_wdata_o;
    logic        data_we_o;
    logic [7:0]  data_be_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        kill_req_o;
    logic        tag_valid_o;
    logic        data_rvalid_i;
    logic [63:0] data_rdata_i;

    int checks = 0;
    int errors = 0;

    dcache_req_adapter #(.INDEX_W(12), .TAG_W(44)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_we_i        (req_we_i),
        .req_be_i        (req_be_i),
        .req_wdata_i     (req_wdata_i),
        .kill_i          (kill_i),
        .resp_valid_o    (resp_valid_o),
        .resp_rdata_o    (resp_rdata_o),
        .address_index_o (address_index_o),
        .address_tag_o   (address_tag_o),
        .data_wdata_o    (data_wdata_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_req_o      (data_req_o),
        .data_gnt_i      (data_gnt_i),
        .kill_req_o      (kill_req_o),
        .tag_valid_o     (tag_valid_o),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the handshake/strobe outputs against one expected row.
    task automatic expectCtl(input string phase, input bit rdy, input bit dreq,
                             input bit tval, input bit kreq, input bit rv);
        checkOutput({phase, ".req_ready"},  64'(req_ready_o),  64'(rdy));
        checkOutput({phase, ".data_req"},   64'(data_req_o),   64'(dreq));
        checkOutput({phase, ".tag_valid"},  64'(tag_valid_o),  64'(tval));
        checkOutput({phase, ".kill_req"},   64'(kill_req_o),   64'(kreq));
        checkOutput({phase, ".resp_valid"}, 64'(resp_valid_o), 64'(rv));
    endtask

    // Quiet inputs: no request, no kill, no cache activity.
    task automatic driveIdle();
        req_valid_i   = 1'b0;
        kill_i        = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
    endtask

    // One complete request.
    //   gntDelay : number of REQ cycles before the grant cycle
    //   killPhase: 0 none, 1 during REQ (killAt = REQ cycle, killAt==gntDelay
    //              means coincident with the grant), 2 after the grant
    //              (killAt = cycles after the tag cycle, 0 is the tag cycle)
    //   rvDelay  : cycles from the tag cycle to data_rvalid_i (reads only)
    task automatic applyStimulus(input bit we, input logic [55:0] addr, input logic [7:0] be,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 input int gntDelay, input int killPhase, input int killAt,
                                 input int rvDelay);
        bit killPend;
        bit killed;
        bit done;
        bit expResp;
        bit k;
        bit rv;

        killPend = 1'b0;
        killed   = 1'b0;
        done     = 1'b0;
        expResp  = 1'b0;

        // Accept cycle; a stray rvalid while idle must be ignored.
        @(negedge clk);
        req_valid_i   = 1'b1;
        req_addr_i    = addr;
        req_we_i      = we;
        req_be_i      = be;
        req_wdata_i   = wdata;
        kill_i        = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'($urandom_range(0, 1));
        data_rdata_i  = {$urandom(), $urandom()};
        #1;
        expectCtl("accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Request phase: fields must be stable until the grant.
        for (int j = 0; j <= gntDelay && !done; j++) begin
            @(negedge clk);
            req_valid_i   = 1'($urandom_range(0, 1));
            req_addr_i    = {$urandom(), $urandom()};
            req_wdata_i   = {$urandom(), $urandom()};
            data_rvalid_i = 1'($urandom_range(0, 1));
            data_gnt_i    = (j == gntDelay);
            k             = (killPhase == 1) && (j == killAt);
            kill_i        = k;
            #1;
            expectCtl("req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("req.index", 64'(address_index_o), 64'(addr[11:0]));
            checkOutput("req.we",    64'(data_we_o),       64'(we));
            checkOutput("req.be",    64'(data_be_o),       64'(be));
            checkOutput("req.wdata", data_wdata_o,         wdata);
            if (k && !data_gnt_i) done = 1'b1;
            if (k && data_gnt_i)  killPend = 1'b1;
        end

        // Tag cycle followed by the read wait (if any).
        for (int w = 0; w < 16 && !done; w++) begin
            @(negedge clk);
            req_valid_i   = 1'($urandom_range(0, 1));
            data_gnt_i    = 1'b0;
            k             = (killPhase == 2) && (w == killAt);
            rv            = !we && (w == rvDelay);
            kill_i        = k;
            data_rvalid_i = rv;
            data_rdata_i  = rdata;
            #1;
            if (w == 0) begin
                expectCtl("tag", 1'b0, 1'b0, 1'b1, killPend | k, 1'b0);
                checkOutput("tag.tag", 64'(address_tag_o), 64'(addr[55:12]));
                if (killPend || k || we) begin
                    done = 1'b1;
                end else if (rv) begin
                    expResp = 1'b1;
                    done    = 1'b1;
                end
            end else begin
                expectCtl("wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                if (k) killed = 1'b1;
                if (rv) begin
                    expResp = !killed;
                    done    = 1'b1;
                end
            end
        end

        // Back in IDLE: ready again; the response (if any) shows here.
        @(negedge clk);
        driveIdle();
        #1;
        expectCtl("end", 1'b1, 1'b0, 1'b0, 1'b0, expResp);
        if (expResp) checkOutput("end.rdata", resp_rdata_o, rdata);
    endtask

    // Reset asserted while a read is waiting, followed by a stray rvalid.
    task automatic resetDuringRead(input logic [55:0] addr);
        @(negedge clk);
        req_valid_i   = 1'b1;
        req_addr_i    = addr;
        req_we_i      = 1'b0;
        req_be_i      = 8'hFF;
        req_wdata_i   = 64'h0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        kill_i        = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        data_gnt_i  = 1'b1;
        @(negedge clk);
        data_gnt_i  = 1'b0;
        #1;
        checkOutput("rstw.tag_valid", 64'(tag_valid_o), 64'd1);
        @(negedge clk);
        // Now waiting for read data; reset hits here.
        rst = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        expectCtl("rstw.inrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstw.index", 64'(address_index_o), 64'd0);
        checkOutput("rstw.tag",   64'(address_tag_o),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expectCtl("rstw.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        driveIdle();
        #1;
        expectCtl("rstw.after2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          we;
        int          gd;
        int          kp;
        int          ka;
        int          rd;
        logic [55:0] a;

        rst          = 1'b1;
        req_addr_i   = '0;
        req_we_i     = 1'b0;
        req_be_i     = '0;
        req_wdata_i  = '0;
        data_rdata_i = '0;
        driveIdle();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        expectCtl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.index", 64'(address_index_o), 64'd0);
        checkOutput("reset.rdata", resp_rdata_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.ready_after", 64'(req_ready_o), 64'd1);

        // A kill while idle blocks acceptance.
        @(negedge clk);
        req_valid_i = 1'b1;
        kill_i      = 1'b1;
        #1;
        checkOutput("idlekill.ready", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        driveIdle();
        #1;
        expectCtl("idlekill.next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Read, immediate grant, data one cycle after the tag.
        applyStimulus(1'b0, 56'h00_0000_1234_5A18, 8'hFF, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 1);
        // Write with the grant in the third request cycle.
        applyStimulus(1'b1, 56'h12_3456_789A_BCDE, 8'h0F, 64'h1122334455667788, 64'h0, 2, 0, 0, 0);
        // Kill before grant.
        applyStimulus(1'b0, 56'h00_00AB_CDEF_0123, 8'hFF, 64'h0, 64'h5555, 3, 1, 1, 1);
        // Kill coincident with the grant.
        applyStimulus(1'b0, 56'h77_0000_0000_0FFF, 8'hFF, 64'h0, 64'h6666, 1, 1, 1, 1);
        // Kill while waiting, data two cycles later is drained.
        applyStimulus(1'b0, 56'h01_0203_0405_0607, 8'hFF, 64'h0, 64'h7777, 0, 2, 1, 3);
        // Kill together with the returning data.
        applyStimulus(1'b0, 56'h0F_0E0D_0C0B_0A09, 8'hFF, 64'h0, 64'h8888, 0, 2, 2, 2);
        // Data in the tag cycle itself.
        applyStimulus(1'b0, 56'hFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 64'hFFFF_0000_FFFF_0000, 1, 0, 0, 0);

        resetDuringRead(56'h00_0000_0000_1234);

        // Randomised requests.
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 4);
            kp = 0;
            ka = 0;
            case ($urandom_range(0, 3))
                1: begin kp = 1; ka = $urandom_range(0, gd); end
                2: begin kp = 2; ka = we ? 0 : $urandom_range(0, rd); end
                default: kp = 0;
            endcase
            a = 56'({$urandom(), $urandom()});
            applyStimulus(we, a, 8'($urandom()), {$urandom(), $urandom()},
                          {$urandom(), $urandom()}, gd, kp, ka, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
